// File: rtl/pixel_upsampler_if.sv
// ---------------------------------------------------------------------------
// pixel_upsampler_if
// Bundles the pixel upsampler's FIFO-side and stream-side signals.
//   din        : FIFO head pixel, valid whenever empty = 0
//   empty      : FIFO empty flag
//   rd_en      : pop request for the FIFO head (combinational in the upsampler)
//   dout       : registered output pixel
//   dout_valid : output beat valid
//   dout_ready : downstream accepts the current beat
//   line_end   : marks the last beat of each output line
//   frame_end  : marks the last beat of each output frame
// Modport master is the upsampler; modport slave is its environment
// (FIFO plus downstream consumer).
// ---------------------------------------------------------------------------
interface pixel_upsampler_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              empty;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              line_end;
    logic              frame_end;

    modport master (
        input  din, empty, dout_ready,
        output rd_en, dout, dout_valid, line_end, frame_end
    );

    modport slave (
        output din, empty, dout_ready,
        input  rd_en, dout, dout_valid, line_end, frame_end
    );
endinterface

// File: rtl/pixel_upsampler.sv
// ---------------------------------------------------------------------------
// pixel_upsampler
// Nearest-neighbour upsampler: every input pixel is emitted FACTOR times
// horizontally and every input line FACTOR times vertically. The first copy
// of a line streams from the FIFO while it is captured in a line buffer; the
// remaining FACTOR-1 copies replay from the line buffer without touching the
// FIFO.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : pixel_upsampler_if.master
//          din/empty/rd_en        - first-word-fall-through FIFO side
//          dout/dout_valid/dout_ready/line_end/frame_end - output stream
// ---------------------------------------------------------------------------
module pixel_upsampler #(
    parameter int DATA_W = 8,
    parameter int LINE_W = 640,
    parameter int LINES  = 480,
    parameter int FACTOR = 2
) (
    input  logic              clk,
    input  logic              rst,
    pixel_upsampler_if.master bus
);
    localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int REP_W = (FACTOR > 1) ? $clog2(FACTOR) : 1;
    localparam int ROW_W = (LINES  > 1) ? $clog2(LINES)  : 1;

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(LINE_W - 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(FACTOR - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(LINES - 1);

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_REPEAT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [COL_W-1:0]  r_col;
    logic [REP_W-1:0]  r_hrep;
    logic [REP_W-1:0]  r_vrep;
    logic [ROW_W-1:0]  r_row;

    logic [DATA_W-1:0] r_linebuf [LINE_W];

    logic [DATA_W-1:0] r_dout_p0;
    logic              r_vld_p0;
    logic              r_le_p0;
    logic              r_fe_p0;

    logic              w_load_ok;
    logic              w_src_avail;
    logic              w_load;
    logic              w_hrep_last;
    logic              w_col_last;
    logic              w_vrep_last;
    logic              w_row_last;
    logic              w_rd_en;
    logic              w_line_end;
    logic              w_frame_end;
    logic [DATA_W-1:0] w_pix;

    // Output register is free when empty or being drained this cycle.
    assign w_load_ok   = !r_vld_p0 || bus.dout_ready;
    assign w_src_avail = (r_state == ST_REPEAT) || !bus.empty;
    assign w_load      = w_load_ok && w_src_avail;

    assign w_hrep_last = (r_hrep == REP_MAX);
    assign w_col_last  = (r_col  == COL_MAX);
    assign w_vrep_last = (r_vrep == REP_MAX);
    assign w_row_last  = (r_row  == ROW_MAX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FIRST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: the state only changes at the end of an output line.
    // With FACTOR=1 the vertical counter is always on its last copy, so the
    // machine never leaves FIRST.
    always_comb begin
        w_state_nxt = r_state;
        if (w_load && w_hrep_last && w_col_last) begin
            w_state_nxt = w_vrep_last ? ST_FIRST : ST_REPEAT;
        end
    end

    // Output logic: pixel source select, FIFO pop and stream markers.
    // The FIFO head is popped only on its last horizontal copy.
    always_comb begin
        w_pix       = (r_state == ST_FIRST) ? bus.din : r_linebuf[r_col];
        w_rd_en     = w_load_ok && !bus.empty && (r_state == ST_FIRST)
                      && w_hrep_last && !rst;
        w_line_end  = w_col_last && w_hrep_last;
        w_frame_end = w_line_end && w_vrep_last && w_row_last;
    end

    // Position counters: hrep -> col -> vrep -> row
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hrep <= '0;
            r_col  <= '0;
            r_vrep <= '0;
            r_row  <= '0;
        end else if (w_load) begin
            if (w_hrep_last) begin
                r_hrep <= '0;
                if (w_col_last) begin
                    r_col <= '0;
                    if (w_vrep_last) begin
                        r_vrep <= '0;
                        r_row  <= w_row_last ? '0 : r_row + 1'b1;
                    end else begin
                        r_vrep <= r_vrep + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end else begin
                r_hrep <= r_hrep + 1'b1;
            end
        end
    end

    // Line buffer capture on the first horizontal copy of each FIFO pixel;
    // contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_load && (r_state == ST_FIRST) && (r_hrep == '0)) begin
            r_linebuf[r_col] <= bus.din;
        end
    end

    // ---- stage p0: registered output beat ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout_p0 <= '0;
            r_vld_p0  <= 1'b0;
            r_le_p0   <= 1'b0;
            r_fe_p0   <= 1'b0;
        end else if (w_load_ok) begin
            if (w_src_avail) begin
                r_dout_p0 <= w_pix;
                r_vld_p0  <= 1'b1;
                r_le_p0   <= w_line_end;
                r_fe_p0   <= w_frame_end;
            end else begin
                r_vld_p0  <= 1'b0;
            end
        end
    end

    assign bus.rd_en      = w_rd_en;
    assign bus.dout       = r_dout_p0;
    assign bus.dout_valid = r_vld_p0;
    assign bus.line_end   = r_le_p0;
    assign bus.frame_end  = r_fe_p0;
endmodule

// File: tb/tb_pixel_upsampler.sv
// ---------------------------------------------------------------------------
// tb_pixel_upsampler
// Three upsampler instances share clk/rst/din/dout_ready:
//   0: LINE_W=4 LINES=2 FACTOR=2   1: LINE_W=3 LINES=1 FACTOR=1
//   2: LINE_W=3 LINES=1 FACTOR=3
// Only the instance selected by 'active' sees a non-empty FIFO. A queue
// models the FIFO; expected beats are pushed to a scoreboard when a frame
// is queued and popped as the DUT hands beats over.
// ---------------------------------------------------------------------------
module tb_pixel_upsampler;
    typedef logic [9:0] exp_t;   // {line_end, frame_end, pixel}

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r_ready = 1'b1;
    logic [7:0] r_din = '0;
    logic [2:0] r_empty = '1;

    logic [7:0] w_dout [3];
    logic [2:0] w_vld;
    logic [2:0] w_le;
    logic [2:0] w_fe;
    logic [2:0] w_rd;

    int cfg_lw [3] = '{4, 3, 3};
    int cfg_ln [3] = '{2, 1, 1};
    int cfg_f  [3] = '{2, 1, 3};

    logic [7:0] fifo [$];
    logic [7:0] pend [$];
    exp_t       sb   [$];

    int   active = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   pops = 0;
    int   beat_n = 0;
    int   line_start = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    bit   bp = 1'b0;
    bit   starve = 1'b0;
    bit   chk_rep = 1'b0;
    bit   prev_stall = 1'b0;
    logic [10:0] prev_bus = '0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LW = (g == 0) ? 4 : 3;
        localparam int LN = (g == 0) ? 2 : 1;
        localparam int FF = (g == 0) ? 2 : ((g == 1) ? 1 : 3);

        pixel_upsampler_if #(.DATA_W(8)) ifc ();

        assign ifc.din        = r_din;
        assign ifc.empty      = r_empty[g];
        assign ifc.dout_ready = r_ready;
        assign w_dout[g]      = ifc.dout;
        assign w_vld[g]       = ifc.dout_valid;
        assign w_le[g]        = ifc.line_end;
        assign w_fe[g]        = ifc.frame_end;
        assign w_rd[g]        = ifc.rd_en;

        pixel_upsampler #(
            .DATA_W(8), .LINE_W(LW), .LINES(LN), .FACTOR(FF)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc.master)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model: pop on rd_en at the edge, then refresh head/empty.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && w_rd[active]) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            pops = pops + 1;
        end
        #1;
        for (int g = 0; g < 3; g++) r_empty[g] = (g != active) || (fifo.size() == 0);
        r_din = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        int a;
        int lpix;
        logic [10:0] cur;
        exp_t exp_v;
        a = active;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (w_rd[a]) begin
                chk("rd_while_empty", 32'(r_empty[a]), 32'd0);
                chk("rd_while_stalled", 32'(w_vld[a] & ~r_ready), 32'd0);
            end
            cur = {w_vld[a], w_le[a], w_fe[a], w_dout[a]};
            if (prev_stall) chk("stall_hold", 32'(cur), 32'(prev_bus));
            if (w_vld[a] && r_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", 32'(cur), 32'd0);
                end else begin
                    exp_v = sb.pop_front();
                    chk("beat", 32'({w_le[a], w_fe[a], w_dout[a]}), 32'(exp_v));
                end
                lpix = cfg_lw[a] * cfg_f[a];
                if (beat_n % lpix == 0) line_start = cyc;
                if (chk_rep && (beat_n % lpix == lpix - 1) && ((beat_n / lpix) % cfg_f[a] != 0))
                    chk("repeat_line_stream", 32'(cyc - line_start), 32'(lpix - 1));
                if (beat_n == 0) first_cyc = cyc;
                last_cyc = cyc;
                beat_n++;
            end
            prev_stall = w_vld[a] && !r_ready;
            prev_bus   = cur;
        end
    end

    // Queue one input frame (pixels base+1 ..) and its expected output beats.
    task automatic load_frame(input int g, input int base);
        int lw = cfg_lw[g];
        int ln = cfg_ln[g];
        int f  = cfg_f[g];
        logic le;
        logic fe;
        for (int i = 0; i < lw * ln; i++) begin
            if (starve) pend.push_back(8'(base + i + 1));
            else        fifo.push_back(8'(base + i + 1));
        end
        for (int r = 0; r < ln; r++)
            for (int v = 0; v < f; v++)
                for (int c = 0; c < lw; c++)
                    for (int h = 0; h < f; h++) begin
                        le = (c == lw - 1) && (h == f - 1);
                        fe = le && (v == f - 1) && (r == ln - 1);
                        sb.push_back({le, fe, 8'(base + r * lw + c + 1)});
                    end
    endtask

    task automatic run(input int max_cyc);
        int n = 0;
        while ((sb.size() != 0 || fifo.size() != 0 || pend.size() != 0) && n < max_cyc) begin
            @(posedge clk);
            #2;
            n++;
            if (bp) r_ready = 1'($urandom_range(0, 1));
            if (starve && pend.size() > 0 && (n % 5 == 0)) fifo.push_back(pend.pop_front());
        end
        chk("run_timeout", 32'(n < max_cyc), 32'd1);
        r_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic start_test();
        beat_n = 0;
        pops   = 0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_dout", 32'(w_dout[0]), 32'd0);
        chk("reset_valid", 32'(w_vld[0]), 32'd0);
        chk("reset_line_end", 32'(w_le[0]), 32'd0);
        chk("reset_frame_end", 32'(w_fe[0]), 32'd0);
        @(posedge clk);
        #2;

        // Basic frame, ready held high
        start_test();
        chk_rep = 1'b1;
        load_frame(0, 0);
        run(300);
        chk("basic_beats", 32'(beat_n), 32'd32);
        chk("basic_pops", 32'(pops), 32'd8);
        chk("basic_no_bubble", 32'(last_cyc - first_cyc), 32'd31);

        // Random back-pressure
        start_test();
        chk_rep = 1'b0;
        bp = 1'b1;
        load_frame(0, 0);
        run(800);
        bp = 1'b0;
        chk("bp_beats", 32'(beat_n), 32'd32);
        chk("bp_pops", 32'(pops), 32'd8);

        // Starved FIFO: one pixel every 5 cycles
        start_test();
        chk_rep = 1'b1;
        starve = 1'b1;
        load_frame(0, 0);
        run(800);
        starve = 1'b0;
        chk("starve_beats", 32'(beat_n), 32'd32);
        chk("starve_pops", 32'(pops), 32'd8);
        chk("starve_has_gaps", 32'((last_cyc - first_cyc) > 31), 32'd1);

        // FACTOR=1 passthrough
        active = 1;
        start_test();
        load_frame(1, 6);
        run(100);
        chk("f1_beats", 32'(beat_n), 32'd3);
        chk("f1_pops", 32'(pops), 32'd3);
        chk("f1_no_bubble", 32'(last_cyc - first_cyc), 32'd2);

        // FACTOR=3
        active = 2;
        start_test();
        load_frame(2, 6);
        run(200);
        chk("f3_beats", 32'(beat_n), 32'd27);
        chk("f3_pops", 32'(pops), 32'd3);
        chk("f3_no_bubble", 32'(last_cyc - first_cyc), 32'd26);

        // Reset mid-frame after beat 11
        active = 0;
        start_test();
        load_frame(0, 0);
        n = 0;
        while (beat_n < 11 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("rst_wait_timeout", 32'(n < 200), 32'd1);
        rst = 1'b1;
        r_ready = 1'b0;
        fifo.delete();
        sb.delete();
        @(negedge clk);
        chk("rst_no_pop", 32'(w_rd[0]), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        r_ready = 1'b1;
        @(negedge clk);
        chk("midrst_dout", 32'(w_dout[0]), 32'd0);
        chk("midrst_valid", 32'(w_vld[0]), 32'd0);
        chk("midrst_line_end", 32'(w_le[0]), 32'd0);
        chk("midrst_frame_end", 32'(w_fe[0]), 32'd0);
        @(posedge clk);
        #2;
        start_test();
        load_frame(0, 0);
        run(300);
        chk("post_rst_beats", 32'(beat_n), 32'd32);
        chk("post_rst_pops", 32'(pops), 32'd8);
        chk("post_rst_no_bubble", 32'(last_cyc - first_cyc), 32'd31);

        // Back-to-back frames
        start_test();
        load_frame(0, 0);
        load_frame(0, 8);
        run(400);
        chk("b2b_beats", 32'(beat_n), 32'd64);
        chk("b2b_pops", 32'(pops), 32'd16);
        chk("b2b_no_bubble", 32'(last_cyc - first_cyc), 32'd63);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pixel_upsampler.md
# pixel_upsampler

Parametrised nearest-neighbour image upsampler for the SIFT scale-space pipeline. It pops pixels from an upstream first-word-fall-through FIFO and emits each pixel FACTOR times horizontally. It stores each input line in an internal line buffer and replays that line so each line is emitted FACTOR times vertically. The output is a registered valid/ready stream carrying line and frame markers, feeding the next pyramid stage.

## Interface
- DATA_W, 8, pixel width in bits
- LINE_W, 640, input pixels per line (≥2)
- LINES, 480, input lines per frame (≥1)
- FACTOR, 2, replication factor in both dimensions (1..8; 1 = passthrough)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- din  in  DATA_W  FIFO head pixel, valid whenever empty=0
- empty  in  1  FIFO empty
- rd_en  out  1  pop FIFO head this cycle (combinational)
- dout  out  DATA_W  output pixel (registered)
- dout_valid  out  1  output beat valid
- dout_ready  in  1  downstream accepts beat
- line_end  out  1  qualifies last beat of each output line
- frame_end  out  1  qualifies last beat of each output frame

## Operation
- Counters: col (0..LINE_W-1), hrep (0..FACTOR-1), vrep (0..FACTOR-1), row (0..LINES-1); widths $clog2 of range, minimum 1.
- Line buffer: LINE_W x DATA_W array; synchronous write, combinational read (distributed RAM).
- The load condition is load_ok = (!dout_valid || dout_ready). The output register loads one beat per cycle in which load_ok holds and a source is available.
- State FIRST (reset state): source is FIFO head; available iff empty=0.
  - On load with hrep=0: write din to linebuf[col].
  - rd_en = load_ok && !empty && state==FIRST && hrep==FACTOR-1 (pop after the last horizontal copy). rd_en is never asserted while empty=1 or rst=1.
- State REPEAT: source is linebuf[col]; always available; FIFO is ignored and never popped.
- Counter advance on each load: hrep++. At hrep wrap: col++. At col wrap (end of output line): vrep++.
  - At vrep wrap: row++ (wraps at LINES) and state←FIRST.
  - Otherwise: state←REPEAT.
- FACTOR=1: REPEAT is never entered. Every load pops the FIFO. Output equals input.
- line_end is loaded with the beat as (col==LINE_W-1 && hrep==FACTOR-1). frame_end is loaded as line_end && vrep==FACTOR-1 && row==LINES-1.
- If load_ok holds but no source is available (FIRST and empty=1), dout_valid←0 and the counters hold.
- Output frame: LINE_W*FACTOR beats per line, LINES*FACTOR lines.

## Timing
- Reset values: dout=0, dout_valid=0, line_end=0, frame_end=0. State FIRST, all counters 0. Line buffer contents are not cleared.
- Latency: a pixel at the FIFO head with empty=0 in cycle N, with load_ok, appears on dout with dout_valid=1 at cycle N+1.
- Throughput: 1 beat/cycle while dout_ready=1 and (REPEAT or empty=0). There is no bubble at FIRST↔REPEAT transitions or at line and frame wraps.
- Stall: while dout_valid=1 and dout_ready=0, dout/line_end/frame_end hold. There is no pop and counters are frozen.
- Empty mid-line in FIRST: the current beat completes, then dout_valid drops. Output resumes the cycle after empty deasserts, at the same col/hrep.
- Reset mid-frame: on the rst cycle, outputs go to reset values on the next edge. The partial frame is abandoned and the next non-empty pixel is treated as row 0, col 0. No pop occurs during rst.
- Simultaneous accept and load: when dout_ready=1 and dout_valid=1, the next beat loads in the same cycle (no skid).

## Test plan
- Basic: LINE_W=4, LINES=2, FACTOR=2; FIFO preloaded 1..8, dout_ready=1.
  - Required: 32 consecutive beats: 1,1,2,2,3,3,4,4 twice, then 5,5,6,6,7,7,8,8 twice.
  - line_end on beats 8/16/24/32; frame_end only on beat 32; exactly 8 rd_en pulses, each on the second copy of a pixel.
- Back-pressure: same config, dout_ready toggling with a random 50% pattern.
  - Required: identical beat sequence; dout stable across every stalled cycle; no rd_en while stalled.
- Starvation: FIFO supplies one pixel every 5 cycles.
  - Required: dout_valid=0 gaps only in FIRST lines; REPEAT lines stream at 1 beat/cycle; rd_en never asserted while empty=1.
- FACTOR=1 and FACTOR=3 (LINE_W=3, LINES=1, input 7,8,9).
  - Required for FACTOR=1: output 7,8,9 with line_end and frame_end on 9.
  - Required for FACTOR=3: 7,7,7,8,8,8,9,9,9 three times; 27 beats; frame_end on beat 27.
- Reset mid-frame: assert rst after beat 11 of the basic test, then refill the FIFO with 1..8.
  - Required: outputs 0 the cycle after rst; the fresh frame matches the basic-test sequence exactly.
- Back-to-back frames: 16 pixels, LINES=2, LINE_W=4.
  - Required: two frames of 32 beats, no bubble at the frame boundary, frame_end on beats 32 and 64.
